// File: rtl/dma_tx_pkg.sv
// Shared types and helpers for the DMA request-path arbiter.
// Optional build macro: DMA_TX_ARB_STORE_FWD_EN (store-and-forward eligibility).
package dma_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_SEND = 2'b10
  } state_t;

  localparam int MAX_CH = 8;

  function automatic int fifo_w(
    int data_w,
    int user_w,
    int keep_w
  );
    return data_w + user_w + keep_w + 1;
  endfunction

  // First requester after ptr, wrapping at n; returns ptr when none request.
  function automatic logic [2:0] rr_pick(
    logic [MAX_CH-1:0] req,
    logic [2:0]        ptr,
    int                n
  );
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && k <= n && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dma_tx_ch_fifo.sv
// Per-channel ingress register, FWFT sync FIFO and prog-full ready.
// DMA_TX_ARB_STORE_FWD_EN adds a whole-packet counter for eligibility.
module dma_tx_ch_fifo
  import dma_tx_pkg::*;
#(
  parameter int DATA_W       = 128,
  parameter int USER_W       = 60,
  parameter int KEEP_W       = DATA_W / 32,
  parameter int FIFO_DEPTH   = 512,
  parameter int PFULL_THRESH = FIFO_DEPTH - 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [USER_W-1:0] in_tuser,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] out_tdata,
  output logic [USER_W-1:0] out_tuser,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tlast,
  output logic              empty,
  output logic              eligible
);

  localparam int FW = fifo_w(DATA_W, USER_W, KEEP_W);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] in_q;
  logic [FW-1:0] dout;
  logic          in_v;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pfull;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pfull = count >= (AW+1)'(PFULL_THRESH);
  assign wr_ok = in_v && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  assign {out_tlast, out_tuser,
          out_tkeep, out_tdata} = dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v      <= 1'b0;
      in_q      <= '0;
      in_tready <= 1'b0;
    end else begin
      in_v      <= in_tvalid && in_tready;
      in_tready <= !pfull;
      if (in_tvalid && in_tready)
        in_q <= {in_tlast, in_tuser,
                 in_tkeep, in_tdata};
      if (in_v)
        assert (!full);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      mem[wr_ptr] <= in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef DMA_TX_ARB_STORE_FWD_EN
  logic [AW:0] pkt_cnt;
  logic [AW:0] wr_run;
  logic        pkt_inc;
  logic        pkt_dec;

  assign pkt_inc  = wr_ok && in_q[FW-1];
  assign pkt_dec  = rd_ok && dout[FW-1];
  assign eligible = pkt_cnt != '0;

  // wr_run counts beats of the packet being written so far
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
      wr_run  <= '0;
    end else begin
      if (pkt_inc && !pkt_dec)
        pkt_cnt <= pkt_cnt + 1'b1;
      else if (pkt_dec && !pkt_inc)
        pkt_cnt <= pkt_cnt - 1'b1;
      if (wr_ok) begin
        assert (wr_run < (AW+1)'(PFULL_THRESH));
        wr_run <= in_q[FW-1] ? '0
                             : wr_run + 1'b1;
      end
    end
  end
`else
  assign eligible = !empty;
`endif

endmodule

// File: rtl/dma_tx_arb.sv
// N-channel packet-atomic round-robin arbiter onto the PCIe RQ stream.
// Build macro DMA_TX_ARB_STORE_FWD_EN selects store-and-forward eligibility.
module dma_tx_arb
  import dma_tx_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 128,
  parameter int USER_W       = 60,
  parameter int KEEP_W       = DATA_W / 32,
  parameter int FIFO_DEPTH   = 512,
  parameter int PFULL_THRESH = FIFO_DEPTH - 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_tdata,
  input  logic [NUM_CH*USER_W-1:0] ch_tuser,
  input  logic [NUM_CH*KEEP_W-1:0] ch_tkeep,
  input  logic [NUM_CH-1:0]        ch_tlast,
  input  logic [NUM_CH-1:0]        ch_tvalid,
  output logic [NUM_CH-1:0]        ch_tready,
  output logic [DATA_W-1:0]        s_axis_rq_tdata,
  output logic [USER_W-1:0]        s_axis_rq_tuser,
  output logic [KEEP_W-1:0]        s_axis_rq_tkeep,
  output logic                     s_axis_rq_tlast,
  output logic                     s_axis_rq_tvalid,
  input  logic                     s_axis_rq_tready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_ch,
  output logic                     busy
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rd_en;
  logic [DATA_W-1:0] f_data [NUM_CH];
  logic [USER_W-1:0] f_user [NUM_CH];
  logic [KEEP_W-1:0] f_keep [NUM_CH];
  logic              f_last [NUM_CH];

  state_t            state;
  logic [GW-1:0]     rr_ptr;
  logic [MAX_CH-1:0] req;
  logic [2:0]        pick;
  logic              hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_tx_ch_fifo #(
      .DATA_W       (DATA_W),
      .USER_W       (USER_W),
      .KEEP_W       (KEEP_W),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .PFULL_THRESH (PFULL_THRESH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_tdata  (ch_tdata[g*DATA_W +: DATA_W]),
      .in_tuser  (ch_tuser[g*USER_W +: USER_W]),
      .in_tkeep  (ch_tkeep[g*KEEP_W +: KEEP_W]),
      .in_tlast  (ch_tlast[g]),
      .in_tvalid (ch_tvalid[g]),
      .in_tready (ch_tready[g]),
      .rd_en     (rd_en[g]),
      .out_tdata (f_data[g]),
      .out_tuser (f_user[g]),
      .out_tkeep (f_keep[g]),
      .out_tlast (f_last[g]),
      .empty     (empty[g]),
      .eligible  (elig[g])
    );
  end

  always_comb begin
    req = '0;
    req[NUM_CH-1:0] = elig;
  end

  assign pick = rr_pick(req, 3'(rr_ptr), NUM_CH);

  assign s_axis_rq_tvalid = busy && !empty[grant_ch];
  assign hs = s_axis_rq_tvalid && s_axis_rq_tready;

  // Gate with tvalid so idle/empty cycles present zeros, not stale FIFO words
  assign s_axis_rq_tdata = s_axis_rq_tvalid ? f_data[grant_ch] : '0;
  assign s_axis_rq_tuser = s_axis_rq_tvalid ? f_user[grant_ch] : '0;
  assign s_axis_rq_tkeep = s_axis_rq_tvalid ? f_keep[grant_ch] : '0;
  assign s_axis_rq_tlast = s_axis_rq_tvalid && f_last[grant_ch];

  always_comb begin
    rd_en = '0;
    rd_en[grant_ch] = hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_ch <= '0;
      busy     <= 1'b0;
      rr_ptr   <= GW'(NUM_CH - 1);
    end else begin
      unique case (1'b1)
        state[0]: begin
          if (|elig) begin
            grant_ch <= GW'(pick);
            busy     <= 1'b1;
            state    <= ST_SEND;
          end
        end
        state[1]: begin
          if (hs && s_axis_rq_tlast) begin
            rr_ptr <= grant_ch;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
